// File: rtl/sim_config_ctrl.sv
// Run/configuration controller for the elevator simulator: keypad edge decode, run FSM,
// decimal entry accumulator and saturating setting registers.
//
// state     | meaning
// ST_START  | idle; configuration keys (digits, C/D/E/F) are honoured
// ST_SIM    | simulation running
// ST_PAUSE  | simulation paused; resume or end
// ST_ENDING | simulation finished; B returns to START
module sim_config_ctrl #(
    parameter int NUM_SETTINGS = 4,
    parameter int VAL_W        = 6,
    parameter logic [NUM_SETTINGS*VAL_W-1:0] SET_MAX     = {6'd7, 6'd3, 6'd3, 6'd63},
    parameter logic [NUM_SETTINGS*VAL_W-1:0] SET_DEFAULT = {6'd1, 6'd0, 6'd0, 6'd0},
    parameter int SEL_W        = $clog2(NUM_SETTINGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    buttonBus,
    input  logic                          pressed,
    output logic [1:0]                    simState,
    output logic [SEL_W-1:0]              setting,
    output logic [VAL_W-1:0]              entry,
    output logic [NUM_SETTINGS*VAL_W-1:0] settings,
    output logic                          commit,
    output logic                          clipped,
    output logic                          entry_ovf
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_SIM    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ENDING = 2'd3
    } run_state_t;

    localparam logic [3:0] KEY_STOP   = 4'hA;
    localparam logic [3:0] KEY_RESUME = 4'hB;
    localparam logic [3:0] KEY_UP     = 4'hC;
    localparam logic [3:0] KEY_DOWN   = 4'hD;
    localparam logic [3:0] KEY_ESC    = 4'hE;
    localparam logic [3:0] KEY_ENTER  = 4'hF;

    run_state_t                    state_q, state_d;
    logic                          pressed_q;
    logic                          key;
    logic [SEL_W-1:0]              setting_d;
    logic [VAL_W-1:0]              entry_d;
    logic                          ovf_d;
    logic [NUM_SETTINGS*VAL_W-1:0] settings_d;
    logic                          commit_d;
    logic                          clipped_d;
    logic [VAL_W+3:0]              acc_t;
    logic [VAL_W-1:0]              cur_max;

    assign key      = pressed & ~pressed_q;
    assign simState = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_START;
            pressed_q <= 1'b0;
            setting   <= '0;
            entry     <= '0;
            entry_ovf <= 1'b0;
            settings  <= SET_DEFAULT;
            commit    <= 1'b0;
            clipped   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pressed_q <= pressed;
            setting   <= setting_d;
            entry     <= entry_d;
            entry_ovf <= ovf_d;
            settings  <= settings_d;
            commit    <= commit_d;
            clipped   <= clipped_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        setting_d  = setting;
        entry_d    = entry;
        ovf_d      = entry_ovf;
        settings_d = settings;
        commit_d   = 1'b0;
        clipped_d  = 1'b0;
        cur_max    = SET_MAX[int'(setting)*VAL_W +: VAL_W];
        // Extra 4 bits hold entry*10+9 for any entry value without wrapping.
        acc_t      = (VAL_W+4)'(entry) * (VAL_W+4)'(10) + (VAL_W+4)'(buttonBus);

        if (key) begin
            unique case (state_q)
                ST_START: begin
                    if (buttonBus == KEY_RESUME) begin
                        state_d = ST_SIM;
                        entry_d = '0;
                        ovf_d   = 1'b0;
                    end else if (buttonBus <= 4'd9) begin
                        if (acc_t > (VAL_W+4)'({VAL_W{1'b1}})) begin
                            entry_d = '1;
                            ovf_d   = 1'b1;
                        end else begin
                            entry_d = acc_t[VAL_W-1:0];
                        end
                    end else if (buttonBus == KEY_UP) begin
                        setting_d = (setting == SEL_W'(NUM_SETTINGS-1)) ? '0 : setting + 1'b1;
                        entry_d   = '0;
                        ovf_d     = 1'b0;
                    end else if (buttonBus == KEY_DOWN) begin
                        setting_d = (setting == '0) ? SEL_W'(NUM_SETTINGS-1) : setting - 1'b1;
                        entry_d   = '0;
                        ovf_d     = 1'b0;
                    end else if (buttonBus == KEY_ESC) begin
                        entry_d = '0;
                        ovf_d   = 1'b0;
                    end else if (buttonBus == KEY_ENTER) begin
                        commit_d  = 1'b1;
                        clipped_d = (entry > cur_max);
                        settings_d[int'(setting)*VAL_W +: VAL_W] = (entry > cur_max) ? cur_max : entry;
                        entry_d   = '0;
                        ovf_d     = 1'b0;
                    end
                end
                ST_SIM: begin
                    if (buttonBus == KEY_STOP) state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (buttonBus == KEY_RESUME)    state_d = ST_SIM;
                    else if (buttonBus == KEY_STOP) state_d = ST_ENDING;
                end
                ST_ENDING: begin
                    if (buttonBus == KEY_RESUME) state_d = ST_START;
                end
                default: state_d = ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_config_ctrl.sv
// Directed plus randomized keypad sequences for sim_config_ctrl, checked against an
// integer-arithmetic model of the run/configuration rules.
module tb_sim_config_ctrl;
    localparam int N = 4;
    localparam int W = 6;
    localparam int MAXV = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     buttonBus = 4'd0;
    logic           pressed = 1'b0;
    logic [1:0]     simState;
    logic [1:0]     setting;
    logic [W-1:0]   entry;
    logic [N*W-1:0] settings;
    logic           commit;
    logic           clipped;
    logic           entry_ovf;

    sim_config_ctrl dut (
        .clk(clk), .rst_n(rst_n), .buttonBus(buttonBus), .pressed(pressed),
        .simState(simState), .setting(setting), .entry(entry), .settings(settings),
        .commit(commit), .clipped(clipped), .entry_ovf(entry_ovf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int m_state, m_setting, m_entry, m_ovf, m_commit, m_clipped;
    int m_settings[N];
    int mx[N]   = '{63, 3, 3, 7};
    int dflt[N] = '{0, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},   32'(simState),  32'(m_state));
        chk({tag, ".setting"}, 32'(setting),   32'(m_setting));
        chk({tag, ".entry"},   32'(entry),     32'(m_entry));
        chk({tag, ".ovf"},     32'(entry_ovf), 32'(m_ovf));
        chk({tag, ".commit"},  32'(commit),    32'(m_commit));
        chk({tag, ".clipped"}, 32'(clipped),   32'(m_clipped));
        for (int i = 0; i < N; i++)
            chk($sformatf("%s.set%0d", tag, i), 32'(settings[i*W +: W]), 32'(m_settings[i]));
    endtask

    task automatic model_reset();
        m_state = 0; m_setting = 0; m_entry = 0; m_ovf = 0; m_commit = 0; m_clipped = 0;
        for (int i = 0; i < N; i++) m_settings[i] = dflt[i];
    endtask

    task automatic model_key(input int c);
        int t;
        m_commit  = 0;
        m_clipped = 0;
        case (m_state)
            0: begin
                if (c == 11) begin
                    m_state = 1; m_entry = 0; m_ovf = 0;
                end else if (c <= 9) begin
                    t = m_entry * 10 + c;
                    if (t > MAXV) begin m_entry = MAXV; m_ovf = 1; end
                    else m_entry = t;
                end else if (c == 12) begin
                    m_setting = (m_setting + 1) % N; m_entry = 0; m_ovf = 0;
                end else if (c == 13) begin
                    m_setting = (m_setting + N - 1) % N; m_entry = 0; m_ovf = 0;
                end else if (c == 14) begin
                    m_entry = 0; m_ovf = 0;
                end else if (c == 15) begin
                    m_commit  = 1;
                    m_clipped = (m_entry > mx[m_setting]) ? 1 : 0;
                    m_settings[m_setting] = (m_entry > mx[m_setting]) ? mx[m_setting] : m_entry;
                    m_entry = 0; m_ovf = 0;
                end
            end
            1: if (c == 10) m_state = 2;
            2: begin
                if (c == 11) m_state = 1;
                else if (c == 10) m_state = 3;
            end
            3: if (c == 11) m_state = 0;
            default: ;
        endcase
    endtask

    // Called at a falling edge; holds the key for hold_cyc cycles then releases for one.
    task automatic press(input int c, input int hold_cyc, input string tag);
        buttonBus = 4'(c);
        pressed   = 1'b1;
        model_key(c);
        @(negedge clk);
        check_all(tag);
        m_commit  = 0;
        m_clipped = 0;
        for (int k = 1; k < hold_cyc; k++) begin
            @(negedge clk);
            check_all({tag, ".hold"});
        end
        pressed = 1'b0;
        @(negedge clk);
        check_all({tag, ".idle"});
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        press(11, 1, "t1_B"); press(10, 1, "t1_A"); press(10, 1, "t1_A2"); press(11, 1, "t1_B2");

        press(4, 1, "t2_4"); press(2, 1, "t2_2"); press(15, 1, "t2_F");

        press(5, 10, "t3_hold5");
        press(5, 1, "t3_5");

        press(12, 1, "t4_C1"); press(12, 1, "t4_C2"); press(12, 1, "t4_C3");
        press(9, 1, "t4_9"); press(15, 1, "t4_F");
        press(12, 1, "t4_wrapC"); press(13, 1, "t4_wrapD");
        press(0, 1, "t4_0"); press(15, 1, "t4_Fzero");

        press(9, 1, "t5_9"); press(9, 1, "t5_99"); press(14, 1, "t5_E");
        press(6, 1, "t5_6"); press(11, 1, "t5_leave");

        press(3, 1, "t6_3"); press(12, 1, "t6_C"); press(15, 1, "t6_F");
        press(10, 1, "t6_A"); press(10, 1, "t6_A2"); press(11, 1, "t6_B");
        press(4, 1, "t6_4"); press(12, 1, "t6_C2"); press(7, 1, "t6_7");

        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all("t6_after_reset");

        for (int r = 0; r < 400; r++) begin
            int c;
            int roll;
            roll = int'($urandom_range(0, 99));
            // Bias toward START-state traffic so configuration paths get exercised.
            if (roll < 55)      c = int'($urandom_range(0, 9));
            else if (roll < 90) c = int'($urandom_range(12, 15));
            else                c = int'($urandom_range(10, 11));
            press(c, int'($urandom_range(1, 3)), $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
